// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux (unicast/broadcast, out-of-range drops counted); 1-cycle latency.
// Back-pressure: input stalls until every still-pending channel retires; broadcast retires per channel.
module stream_demux_1xn #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [CNTW-1:0]      drop_cnt
);

  localparam logic [SELW:0] NLIM = (SELW+1)'(N);

  logic [WIDTH-1:0] data_q;
  logic [N-1:0]     pend_q;
  logic [N-1:0]     pend_d;
  logic [N-1:0]     sel_onehot;
  logic [CNTW-1:0]  drop_q;
  logic             accept;
  logic             sel_ok;
  logic             load;
  logic             drop;

  // Ready only when every channel still owed the beat is taking it this cycle.
  assign in_ready = ~|(pend_q & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign sel_ok   = {1'b0, in_sel} < NLIM;
  assign load     = accept & (in_bcast | sel_ok);
  assign drop     = accept & ~in_bcast & ~sel_ok;

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (in_sel == i[SELW-1:0]) sel_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    pend_d = pend_q & ~out_ready;
    if (accept) begin
      if (in_bcast)    pend_d = '1;
      else if (sel_ok) pend_d = sel_onehot;
      else             pend_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (load) data_q <= in_data;
      if (drop && (drop_q != {CNTW{1'b1}})) drop_q <= drop_q + CNTW'(1);
    end
  end

  assign out_valid = pend_q;
  assign drop_cnt  = drop_q;

  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = data_q;
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: N=4 instance checked by a per-channel scoreboard plus
// cycle checks; N=3/CNTW=2 instance exercises out-of-range drops and counter saturation.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // N=4 instance
  logic        rst4_n, v4, r4, b4;
  logic [7:0]  d4;
  logic [1:0]  s4;
  logic [3:0]  ov4, or4;
  logic [31:0] od4;
  logic [7:0]  dc4;

  // N=3, CNTW=2 instance
  logic        rst3_n, v3, r3, b3;
  logic [7:0]  d3;
  logic [1:0]  s3;
  logic [2:0]  ov3, or3;
  logic [23:0] od3;
  logic [1:0]  dc3;

  stream_demux_1xn #(.WIDTH(8), .N(4), .CNTW(8)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
    .in_sel(s4), .in_bcast(b4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .drop_cnt(dc4)
  );

  stream_demux_1xn #(.WIDTH(8), .N(3), .CNTW(2)) dut3 (
    .clk(clk), .rst_n(rst3_n), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .in_sel(s3), .in_bcast(b3), .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .drop_cnt(dc3)
  );

  typedef struct {
    int         ch;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed handshake on dut4 must match the oldest expected beat for that channel.
  always @(negedge clk) begin
    int idx;
    if (rst4_n) begin
      for (int i = 0; i < 4; i++) begin
        if (ov4[i] && or4[i]) begin
          idx = -1;
          foreach (sb[j]) if (idx < 0 && sb[j].ch == i) idx = j;
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected ch=%0d actual=%h expected=none", i, od4[i*8 +: 8]);
          end else begin
            chk($sformatf("sb_data_ch%0d", i), {24'd0, od4[i*8 +: 8]}, {24'd0, sb[idx].d});
            sb.delete(idx);
          end
        end
      end
    end
  end

  logic [3:0] bc_rdy [4] = '{4'b0011, 4'b0000, 4'b0100, 4'b1000};
  logic [3:0] bc_vld [4] = '{4'b1111, 4'b1100, 4'b1100, 4'b1000};
  logic       bc_in  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] uc_dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst4_n = 1'b0; rst3_n = 1'b0;
    v4 = 1'b1; d4 = 8'hFF; s4 = 2'd0; b4 = 1'b0; or4 = 4'b1111;
    v3 = 1'b1; d3 = 8'hFF; s3 = 2'd0; b3 = 1'b0; or3 = 3'b111;

    // Reset state, with in_valid held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {28'd0, ov4}, 32'h0);
    chk("rst_out_data",  od4, 32'h0);
    chk("rst_drop_cnt",  {24'd0, dc4}, 32'h0);
    chk("rst_in_ready",  {31'd0, r4}, 32'h1);
    tick;
    rst4_n = 1'b1; rst3_n = 1'b1; v4 = 1'b0; v3 = 1'b0;
    tick;

    // Unicast back-to-back stream
    for (int k = 0; k < 4; k++) begin
      v4 = 1'b1; d4 = uc_dat[k]; s4 = 2'(k); b4 = 1'b0;
      push(k, uc_dat[k]);
      @(negedge clk);
      chk("uc_in_ready", {31'd0, r4}, 32'h1);
      if (k > 0) chk("uc_out_valid", {28'd0, ov4}, 32'(1 << (k - 1)));
      tick;
    end
    v4 = 1'b0;
    @(negedge clk);
    chk("uc_out_valid_last", {28'd0, ov4}, 32'h8);
    tick;
    @(negedge clk);
    chk("uc_idle", {28'd0, ov4}, 32'h0);
    tick;

    // Back-pressure on channel 2 with a queued beat to channel 0
    or4 = 4'b1011;
    v4 = 1'b1; d4 = 8'hA5; s4 = 2'd2;
    push(2, 8'hA5);
    @(negedge clk);
    chk("bp_accept_ready", {31'd0, r4}, 32'h1);
    tick;
    d4 = 8'h5A; s4 = 2'd0;
    push(0, 8'h5A);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {28'd0, ov4}, 32'h4);
      chk("bp_hold_data",  {24'd0, od4[23:16]}, 32'hA5);
      chk("bp_stall",      {31'd0, r4}, 32'h0);
      tick;
    end
    or4 = 4'b1111;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, r4}, 32'h1);
    chk("bp_release_valid", {28'd0, ov4}, 32'h4);
    tick;
    v4 = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {28'd0, ov4}, 32'h1);
    chk("bp_next_data",  {24'd0, od4[7:0]}, 32'h5A);
    tick;

    // Broadcast with staggered readies
    v4 = 1'b1; d4 = 8'hC3; b4 = 1'b1; s4 = 2'd3; or4 = 4'b0000;
    for (int i = 0; i < 4; i++) push(i, 8'hC3);
    tick;
    v4 = 1'b0; b4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      or4 = bc_rdy[k];
      @(negedge clk);
      chk("bc_valid", {28'd0, ov4}, {28'd0, bc_vld[k]});
      chk("bc_ready", {31'd0, r4}, {31'd0, bc_in[k]});
      tick;
    end
    or4 = 4'b0000;
    @(negedge clk);
    chk("bc_done", {28'd0, ov4}, 32'h0);
    tick;

    // Reset in the middle of a partially delivered broadcast
    v4 = 1'b1; d4 = 8'hE7; b4 = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 8'hE7);
    tick;
    v4 = 1'b0; b4 = 1'b0; or4 = 4'b1001;
    tick;
    or4 = 4'b0000;
    @(negedge clk);
    chk("rb_partial_valid", {28'd0, ov4}, 32'h6);
    #1 rst4_n = 1'b0;
    #1;
    chk("rb_async_valid", {28'd0, ov4}, 32'h0);
    chk("rb_async_data",  od4, 32'h0);
    chk("rb_pending_sb",  32'(sb.size()), 32'd2);
    sb.delete();
    tick;
    rst4_n = 1'b1;
    tick;
    or4 = 4'b1111; v4 = 1'b1; d4 = 8'h77; s4 = 2'd1;
    push(1, 8'h77);
    tick;
    v4 = 1'b0;
    @(negedge clk);
    chk("rb_after_valid", {28'd0, ov4}, 32'h2);
    tick;
    @(negedge clk);
    chk("rb_after_idle", {28'd0, ov4}, 32'h0);
    tick;

    // Out-of-range drops on the N=3 instance with a 2-bit saturating counter
    or3 = 3'b111; v3 = 1'b1; d3 = 8'h66; s3 = 2'd1; b3 = 1'b0;
    tick;
    d3 = 8'h99; s3 = 2'd3;
    @(negedge clk);
    chk("drop_prev_valid", {29'd0, ov3}, 32'h2);
    chk("drop_prev_data",  {24'd0, od3[15:8]}, 32'h66);
    chk("drop_in_ready0",  {31'd0, r3}, 32'h1);
    tick;
    for (int k = 1; k < 5; k++) begin
      d3 = 8'h99 + 8'(k);
      @(negedge clk);
      chk("drop_cnt",      {30'd0, dc3}, (k < 3) ? 32'(k) : 32'd3);
      chk("drop_no_valid", {29'd0, ov3}, 32'h0);
      chk("drop_in_ready", {31'd0, r3}, 32'h1);
      chk("drop_data_kept", {8'd0, od3}, 32'h666666);
      tick;
    end
    v3 = 1'b0;
    @(negedge clk);
    chk("drop_cnt_sat", {30'd0, dc3}, 32'd3);
    chk("drop4_cnt_untouched", {24'd0, dc4}, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
